// File: rtl/wb_mem_pipe_if.sv
// Pipelined Wishbone B4 bus bundle between a master and the wb_mem_pipe slave.
// Signal names keep the slave-side _i/_o affixes so they read the same at either end.
interface wb_mem_pipe_if #(
    parameter int unsigned G_ADDR_SIZE = 8,
    parameter int unsigned G_DATA_SIZE = 32
);
    localparam int unsigned SEL_W = G_DATA_SIZE / 8;

    logic                   wb_cyc_i;
    logic                   wb_stb_i;
    logic                   wb_stall_o;
    logic                   wb_we_i;
    logic [G_ADDR_SIZE-1:0] wb_addr_i;
    logic [SEL_W-1:0]       wb_sel_i;
    logic [G_DATA_SIZE-1:0] wb_data_i;
    logic                   wb_ack_o;
    logic                   wb_err_o;
    logic [G_DATA_SIZE-1:0] wb_data_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i,
        input  wb_stall_o, wb_ack_o, wb_err_o, wb_data_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i,
        output wb_stall_o, wb_ack_o, wb_err_o, wb_data_o
    );
endinterface

// File: rtl/wb_mem_pipe.sv
// Pipelined Wishbone B4 slave memory with fixed read latency and byte-lane writes.
// Define WB_MEM_PIPE_ERR_EN to answer out-of-range accesses with wb_err_o instead of ack.
module wb_mem_pipe #(
    parameter int unsigned G_ADDR_SIZE = 8,
    parameter int unsigned G_DATA_SIZE = 32,
    parameter int unsigned G_DEPTH     = 200,
    parameter int unsigned G_LATENCY   = 2
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    wb_mem_pipe_if.slave  wb
);
    localparam int unsigned SEL_W   = G_DATA_SIZE / 8;
    localparam int unsigned IDX_W   = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;
    localparam int unsigned ADDR_XW = G_ADDR_SIZE + 1;
    localparam logic [ADDR_XW-1:0] DEPTH_X = ADDR_XW'(G_DEPTH);

    logic [G_DATA_SIZE-1:0] mem [G_DEPTH];

    logic                   accept;
    logic                   in_range;
    logic [IDX_W-1:0]       idx;
    logic [G_DATA_SIZE-1:0] rd_word;

    logic [G_LATENCY-1:0]   pipe_ack;
    logic [G_DATA_SIZE-1:0] pipe_data [G_LATENCY];

    // Stall only while in reset; there is no internal back-pressure.
    assign wb.wb_stall_o = ~rstn_i;
    assign accept        = wb.wb_cyc_i & wb.wb_stb_i & rstn_i;
    assign in_range      = ({1'b0, wb.wb_addr_i} < DEPTH_X);
    assign idx           = IDX_W'(wb.wb_addr_i);
    assign rd_word       = (accept && in_range) ? mem[idx] : '0;

    // Byte-lane write; the read above samples the pre-write word at the same edge.
    always_ff @(posedge clk_i) begin
        if (accept && wb.wb_we_i && in_range) begin
            for (int k = 0; k < int'(SEL_W); k++) begin
                if (wb.wb_sel_i[k]) begin
                    mem[idx][k*8 +: 8] <= wb.wb_data_i[k*8 +: 8];
                end
            end
        end
    end

`ifdef WB_MEM_PIPE_ERR_EN
    logic [G_LATENCY-1:0] pipe_err;

    // Response pipeline; last stage is the registered bus response.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || !wb.wb_cyc_i) begin
            pipe_ack <= '0;
            pipe_err <= '0;
            for (int i = 0; i < int'(G_LATENCY); i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_ack[0]  <= accept & in_range;
            pipe_err[0]  <= accept & ~in_range;
            pipe_data[0] <= rd_word;
            for (int i = 1; i < int'(G_LATENCY); i++) begin
                pipe_ack[i]  <= pipe_ack[i-1];
                pipe_err[i]  <= pipe_err[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign wb.wb_err_o = pipe_err[G_LATENCY-1];
`else
    // Response pipeline; out-of-range accesses ack with zero data.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || !wb.wb_cyc_i) begin
            pipe_ack <= '0;
            for (int i = 0; i < int'(G_LATENCY); i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_ack[0]  <= accept;
            pipe_data[0] <= rd_word;
            for (int i = 1; i < int'(G_LATENCY); i++) begin
                pipe_ack[i]  <= pipe_ack[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign wb.wb_err_o = 1'b0;
`endif

    assign wb.wb_ack_o  = pipe_ack[G_LATENCY-1];
    assign wb.wb_data_o = pipe_data[G_LATENCY-1];

endmodule

// File: tb/tb_wb_mem_pipe.sv
// Randomized bench for wb_mem_pipe against a queue-based transaction model.
// Honors WB_MEM_PIPE_ERR_EN the same way the design does.
module tb_wb_mem_pipe;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 200;
    localparam int unsigned LAT   = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wb_mem_pipe_if #(.G_ADDR_SIZE(AW), .G_DATA_SIZE(DW)) bus ();

    wb_mem_pipe #(
        .G_ADDR_SIZE(AW), .G_DATA_SIZE(DW), .G_DEPTH(DEPTH), .G_LATENCY(LAT)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .wb     (bus.slave)
    );

    typedef struct {
        int          due;
        bit          err;
        bit          known;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    int          edges    = 0;
    int          checks   = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edges);
        end
    endtask

    // Compare visible outputs with the response due after the latest edge.
    task automatic check_outputs();
        bit          e_ack   = 1'b0;
        bit          e_err   = 1'b0;
        bit          e_known = 1'b1;
        logic [31:0] e_data  = '0;
        rsp_t        r;
        while (exp_q.size() > 0 && exp_q[0].due < edges) void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].due == edges) begin
            r = exp_q.pop_front();
`ifdef WB_MEM_PIPE_ERR_EN
            e_err = r.err;
            e_ack = !r.err;
`else
            e_ack = 1'b1;
`endif
            e_data  = r.data;
            e_known = r.known;
        end
        check_eq("ack",   64'(bus.wb_ack_o),   64'(e_ack));
        check_eq("err",   64'(bus.wb_err_o),   64'(e_err));
        check_eq("stall", 64'(bus.wb_stall_o), 64'(!rstn));
        if (e_known) check_eq("data", 64'(bus.wb_data_o), 64'(e_data));
    endtask

    // Transaction-level effect of the coming clock edge.
    task automatic model_edge(input bit r, input bit cy, input bit st, input bit w,
                              input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
        rsp_t x;
        bit   oor;
        if (!r || !cy) begin
            exp_q.delete();
        end else if (st) begin
            oor     = (int'(a) >= int'(DEPTH));
            x.due   = edges + int'(LAT);
            x.err   = oor;
            x.known = oor ? 1'b1 : ref_known[a];
            x.data  = oor ? 32'h0 : ref_mem[a];
            exp_q.push_back(x);
            if (w && !oor) begin
                for (int k = 0; k < int'(SW); k++) begin
                    if (s[k]) ref_mem[a][k*8 +: 8] = d[k*8 +: 8];
                end
                if (s == 4'hF) ref_known[a] = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit cy, input bit st, input bit w,
                        input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
        check_outputs();
        rstn          = r;
        bus.wb_cyc_i  = cy;
        bus.wb_stb_i  = st;
        bus.wb_we_i   = w;
        bus.wb_addr_i = a;
        bus.wb_sel_i  = s;
        bus.wb_data_i = d;
        model_edge(r, cy, st, w, a, s, d);
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 8'h0, 4'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        rstn          = 1'b0;
        bus.wb_cyc_i  = 1'b0;
        bus.wb_stb_i  = 1'b0;
        bus.wb_we_i   = 1'b0;
        bus.wb_addr_i = '0;
        bus.wb_sel_i  = '0;
        bus.wb_data_i = '0;
        @(posedge clk);
        edges++;
        @(negedge clk);

        // Reset held with an active request: stalled, nothing accepted.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 8'd5, 4'hF, 32'h12345678);

        // Preload every word with 0xA0 + address.
        for (int i = 0; i < int'(DEPTH); i++) step(1, 1, 1, 1, 8'(i), 4'hF, 32'hA0 + 32'(i));
        idle(LAT);

        // Full write then read-after-write.
        step(1, 1, 1, 1, 8'd5, 4'hF, 32'hDEADBEEF);
        step(1, 1, 1, 0, 8'd5, 4'h0, 32'h0);
        idle(LAT - 1);
        check_eq("rd_deadbeef", 64'(bus.wb_data_o), 64'h0000_0000_DEAD_BEEF);
        idle(2);

        // Byte-lane merge.
        step(1, 1, 1, 1, 8'd5, 4'b0101, 32'h11223344);
        step(1, 1, 1, 0, 8'd5, 4'h0, 32'h0);
        idle(LAT - 1);
        check_eq("rd_bytelane", 64'(bus.wb_data_o), 64'h0000_0000_DE22_BE44);
        idle(2);

        // Back-to-back burst reads.
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 8'(i), 4'h0, 32'h0);
        idle(LAT + 2);

        // Abort two in-flight reads, then a fresh read.
        step(1, 1, 1, 0, 8'd10, 4'h0, 32'h0);
        step(1, 1, 1, 0, 8'd11, 4'h0, 32'h0);
        step(1, 0, 0, 0, 8'd0, 4'h0, 32'h0);
        idle(LAT + 2);
        step(1, 1, 1, 0, 8'd12, 4'h0, 32'h0);
        idle(LAT + 1);

        // Out-of-range read and write.
        step(1, 1, 1, 0, 8'd250, 4'h0, 32'h0);
        step(1, 1, 1, 1, 8'd255, 4'hF, 32'hFFFFFFFF);
        idle(LAT + 1);

        // Randomized traffic with occasional aborts and resets.
        for (int n = 0; n < 3000; n++) begin
            bit          r, cy, st, w;
            logic [7:0]  a;
            r  = ($urandom_range(0, 99) >= 2);
            cy = ($urandom_range(0, 99) >= 8);
            st = ($urandom_range(0, 99) < 70);
            w  = $urandom_range(0, 1) == 1;
            a  = ($urandom_range(0, 99) < 88) ? 8'($urandom_range(0, DEPTH - 1))
                                              : 8'($urandom_range(DEPTH, 255));
            step(r, cy, st, w, a, 4'($urandom_range(0, 15)), $urandom);
        end
        idle(LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
